// File: rtl/dotp_pkg.sv
// Shared dot-product definitions: FSM state encoding and width-derivation helpers.
// Also used by the matrix sequencer to size its own result paths.
package dotp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } dotp_state_e;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int dotp_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int dotp_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int dotp_acc_width(input int bw, input int len);
    return 2 * bw + dotp_log2(len);
  endfunction

  function automatic int dotp_cnt_width(input int n);
    return (n > 1) ? dotp_log2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// N_MAC signed multipliers summed at full precision into one pass sum; purely
// combinational, no latency and no flow control.
module mac_lane_sum
  import dotp_pkg::*;
#(
  parameter int N_MAC    = 4,
  parameter int BITWIDTH = 18,
  localparam int SUM_W   = 2 * BITWIDTH + dotp_log2(N_MAC)
) (
  input  logic [N_MAC*BITWIDTH-1:0] w_lane,
  input  logic [N_MAC*BITWIDTH-1:0] x_lane,
  output logic signed [SUM_W-1:0]   lane_sum
);

  // Operands are sign-extended to the sum width first so every product and
  // partial sum is exact; synthesis rebalances the chain into a tree.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < N_MAC; i++) begin
      lane_sum = lane_sum
               + SUM_W'($signed(w_lane[i*BITWIDTH +: BITWIDTH]))
               * SUM_W'($signed(x_lane[i*BITWIDTH +: BITWIDTH]));
    end
  end

endmodule

// File: rtl/dot_prod_engine.sv
// Fixed-point dot product, PASSES=ARRAY_LEN/N_MAC MAC passes; dataReady PASSES+2 cycles after start.
// start is only accepted in IDLE (no queueing); DOTP_SATURATE_EN selects clamping instead of wrap.
module dot_prod_engine
  import dotp_pkg::*;
#(
  parameter int ARRAY_LEN   = 16,
  parameter int N_MAC       = 4,
  parameter int QN          = 6,
  parameter int QM          = 11,
  localparam int BITWIDTH   = dotp_bitwidth(QN, QM)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ARRAY_LEN*BITWIDTH-1:0] weightRow,
  input  logic [ARRAY_LEN*BITWIDTH-1:0] inputVector,
  output logic                          busy,
  output logic                          dataReady,
  output logic signed [BITWIDTH-1:0]    finalResult,
  output logic                          overflow
);

  localparam int PASSES = ARRAY_LEN / N_MAC;
  localparam int LANE_W = N_MAC * BITWIDTH;
  localparam int VEC_W  = ARRAY_LEN * BITWIDTH;
  localparam int ACC_W  = dotp_acc_width(BITWIDTH, ARRAY_LEN);
  localparam int SUM_W  = 2 * BITWIDTH + dotp_log2(N_MAC);
  localparam int PC_W   = dotp_cnt_width(PASSES);

  if (ARRAY_LEN % N_MAC != 0) begin : g_len_check
    $fatal(1, "dot_prod_engine: ARRAY_LEN must be a multiple of N_MAC");
  end

  dotp_state_e             state_q, state_d;
  logic [PC_W-1:0]         pass_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [VEC_W-1:0]        w_q, x_q;
  logic signed [SUM_W-1:0] pass_sum;
  logic [BITWIDTH-1:0]     result_d;
  logic                    ovf_d;
  logic                    last_pass;

  assign last_pass = (pass_q == PC_W'(PASSES - 1));

  mac_lane_sum #(
    .N_MAC    (N_MAC),
    .BITWIDTH (BITWIDTH)
  ) u_lanes (
    .w_lane   (w_q[pass_q*LANE_W +: LANE_W]),
    .x_lane   (x_q[pass_q*LANE_W +: LANE_W]),
    .lane_sum (pass_sum)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    dataReady = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_pass) state_d = FINAL;
      end
      FINAL: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        dataReady = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // Operands are latched at acceptance so the sequencer may move on immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pass_q      <= '0;
      acc_q       <= '0;
      w_q         <= '0;
      x_q         <= '0;
      finalResult <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            w_q    <= weightRow;
            x_q    <= inputVector;
            acc_q  <= '0;
            pass_q <= '0;
          end
        end
        CALC: begin
          acc_q  <= acc_q + ACC_W'(pass_sum);
          pass_q <= last_pass ? '0 : pass_q + 1'b1;
        end
        FINAL: begin
          finalResult <= result_d;
          overflow    <= ovf_d;
        end
        default: ;
      endcase
    end
  end

`ifdef DOTP_SATURATE_EN
  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] scaled;

  always_comb begin
    scaled   = acc_q >>> QM;
    result_d = scaled[BITWIDTH-1:0];
    ovf_d    = 1'b0;
    if (scaled > RES_MAX) begin
      result_d = {1'b0, {(BITWIDTH-1){1'b1}}};
      ovf_d    = 1'b1;
    end else if (scaled < RES_MIN) begin
      result_d = {1'b1, {(BITWIDTH-1){1'b0}}};
      ovf_d    = 1'b1;
    end
  end
`else
  // Floor shift then wrap is just a bit window of the accumulator.
  assign result_d = acc_q[QM +: BITWIDTH];
  assign ovf_d    = 1'b0;
`endif

endmodule
